count_display_scan: RTL and testbench

- Downstream consumer of the 4-bit +1/+2 lab counter.
- Shows the unsigned counter value (0-15) as two decimal digits (tens, units) on a time-multiplexed 2-digit common-anode 7-segment display.
- A refresh prescaler and a small FSM alternate the two digits.
- The input is re-sampled once per scan frame, so a digit pair never tears.

---
 rtl/count_display_pkg.sv | 27 ++
 rtl/bcd_to_7seg.sv | 21 ++
 rtl/count_display_scan.sv | 145 ++++++++++++++
 tb/tb_count_display_scan.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/count_display_pkg.sv
// count_display_pkg
//   Shared types and constants for the 2-digit multiplexed 7-segment
//   display scanner (count_display_scan) and its segment decoder.
//   - scan_state_t : scan FSM states (BLANK, DIG0 = units, DIG1 = tens)
//   - SEG_BLANK    : all segments off (active-low)
//   - SEG_DIGIT    : active-low {g,f,e,d,c,b,a} patterns for digits 0..9
//   - AN_*         : active-low anode enable patterns
package count_display_pkg;

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    DIG0  = 2'd1,
    DIG1  = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  localparam logic [1:0] AN_OFF   = 2'b11;
  localparam logic [1:0] AN_UNITS = 2'b10;  // an[0] low -> units digit lit
  localparam logic [1:0] AN_TENS  = 2'b01;  // an[1] low -> tens digit lit

endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg
//   Combinational decimal digit to active-low 7-segment decoder.
//   Ports:
//     i_digit : 4-bit digit (0..9 meaningful)
//     o_seg   : active-low segments {g,f,e,d,c,b,a}; blank for 10..15
module bcd_to_7seg
  import count_display_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    // Values above 9 cannot occur from the tens/units split; kept dark anyway.
    if (i_digit <= 4'd9) begin
      o_seg = SEG_DIGIT[i_digit];
    end
  end

endmodule

// File: rtl/count_display_scan.sv
// count_display_scan
//   Shows a 4-bit unsigned count (0..15) as two decimal digits on a
//   time-multiplexed, common-anode 2-digit 7-segment display. A refresh
//   prescaler produces a one-cycle tick every REFRESH_CYCLES clocks; the scan
//   FSM steps BLANK -> DIG0 -> DIG1 -> DIG0 ... on each tick. The count is
//   captured into a shadow register only when entering DIG0, so a displayed
//   tens/units pair always comes from a single sample.
//   Optional build macro: COUNT_DISPLAY_LEADING_ZERO_BLANK_EN -- when defined,
//   the tens slot stays dark when the tens digit is 0 (slot duration kept).
//   Ports:
//     clk   : clock, rising edge
//     rst   : asynchronous active-high reset
//     count : 4-bit value from the upstream counter
//     seg   : active-low segments {g,f,e,d,c,b,a}, registered
//     an    : active-low anodes, an[0] = units, an[1] = tens, registered
module count_display_scan
  import count_display_pkg::*;
#(
  parameter int REFRESH_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int PW = $clog2(REFRESH_CYCLES);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_CYCLES - 1);

  logic [PW-1:0] r_presc;
  scan_state_t   r_state;
  scan_state_t   w_state_next;
  logic [3:0]    r_shadow;
  logic [6:0]    r_seg;
  logic [1:0]    r_an;

  logic          w_tick;
  logic          w_capture;
  logic [3:0]    w_shadow_next;
  logic          w_tens_flag;
  logic [3:0]    w_units;
  logic [3:0]    w_tens;
  logic [3:0]    w_digit;
  logic [6:0]    w_dec_seg;
  logic [6:0]    w_seg_next;
  logic [1:0]    w_an_next;

  // Refresh prescaler
  assign w_tick = (r_presc == PRESC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Scan FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BLANK:   if (w_tick) w_state_next = DIG0;
      DIG0:    if (w_tick) w_state_next = DIG1;
      DIG1:    if (w_tick) w_state_next = DIG0;
      default: w_state_next = BLANK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BLANK;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Shadow capture on entry to DIG0 only
  assign w_capture     = w_tick && (w_state_next == DIG0);
  assign w_shadow_next = w_capture ? count : r_shadow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
    end else begin
      r_shadow <= w_shadow_next;
    end
  end

  // Split the value being latched this edge, so the output registers load the
  // freshly captured digits on the same edge as the shadow (1-cycle latency).
  assign w_tens_flag = (w_shadow_next >= 4'd10);
  assign w_units     = w_tens_flag ? (w_shadow_next - 4'd10) : w_shadow_next;
  assign w_tens      = {3'b000, w_tens_flag};
  assign w_digit     = (w_state_next == DIG1) ? w_tens : w_units;

  bcd_to_7seg u_dec (
    .i_digit (w_digit),
    .o_seg   (w_dec_seg)
  );

  // Output values for the state being entered; at most one anode is ever low.
  always_comb begin
    w_an_next  = AN_OFF;
    w_seg_next = SEG_BLANK;
    case (w_state_next)
      DIG0: begin
        w_an_next  = AN_UNITS;
        w_seg_next = w_dec_seg;
      end
      DIG1: begin
`ifdef COUNT_DISPLAY_LEADING_ZERO_BLANK_EN
        if (w_tens_flag) begin
          w_an_next  = AN_TENS;
          w_seg_next = w_dec_seg;
        end
`else
        w_an_next  = AN_TENS;
        w_seg_next = w_dec_seg;
`endif
      end
      default: begin
        w_an_next  = AN_OFF;
        w_seg_next = SEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule

// File: tb/tb_count_display_scan.sv
// tb_count_display_scan
//   Scoreboard bench for count_display_scan with REFRESH_CYCLES = 4.
//   The driver records the count present at every clock edge since reset
//   release and pushes the expected (an, seg) for that edge; a negedge monitor
//   pops and compares. Expectations come from a timeline model: edge k after
//   release is BLANK for k < R, otherwise frame f = (k-R)/R alternates units /
//   tens of the value sampled at the first edge of the even frame.
module tb_count_display_scan;

  localparam int R = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count;
  logic [6:0] seg;
  logic [1:0] an;

  always #5 clk = ~clk;

  count_display_scan #(.REFRESH_CYCLES(R)) dut (
    .clk   (clk),
    .rst   (rst),
    .count (count),
    .seg   (seg),
    .an    (an)
  );

  typedef struct {
    int         id;
    logic [1:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t q[$];
  int   cnt_at [0:4095];
  int   edge_cnt;
  int   errors = 0;
  int   checks = 0;

  // Edges since reset release
  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  function automatic logic [6:0] seg_of(int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic exp_t model(int k);
    exp_t e;
    int f, cap, v;
    e.id  = k;
    e.an  = 2'b11;
    e.seg = 7'h7F;
    if (k >= R) begin
      f   = (k - R) / R;
      cap = R + (f - (f % 2)) * R;
      v   = cnt_at[cap];
      if ((f % 2) == 0) begin
        e.an  = 2'b10;
        e.seg = seg_of(v % 10);
      end else begin
`ifdef COUNT_DISPLAY_LEADING_ZERO_BLANK_EN
        if ((v / 10) != 0) begin
          e.an  = 2'b01;
          e.seg = seg_of(v / 10);
        end
`else
        e.an  = 2'b01;
        e.seg = seg_of(v / 10);
`endif
      end
    end
    return e;
  endfunction

  task automatic check(string name, logic [6:0] act, logic [6:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor: one comparison per presented output cycle
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (an === 2'b00) begin
      errors++;
      $display("FAIL anode_overlap: got an=%b expected never 00 at t=%0t", an, $time);
    end
    if (q.size() > 0) begin
      if (q[0].id < edge_cnt) begin
        e = q.pop_front();
        errors++;
        $display("FAIL missed_entry: got edge %0d expected edge %0d", edge_cnt, e.id);
      end else if (q[0].id == edge_cnt) begin
        e = q.pop_front();
        check($sformatf("an@%0d cnt=%0d", e.id, cnt_at[e.id]), {5'b0, an}, {5'b0, e.an});
        check($sformatf("seg@%0d cnt=%0d", e.id, cnt_at[e.id]), seg, e.seg);
        $display("edge %0d: an=%b seg=%h exp an=%b seg=%h", e.id, an, seg, e.an, e.seg);
      end
    end
  end

  // mode 0: hold val; mode 1: random changes
  task automatic drive_cycles(int n, int mode, int val);
    for (int i = 0; i < n; i++) begin
      if (mode == 0) count = 4'(val);
      else if ($urandom_range(0, 2) == 0) count = 4'($urandom_range(0, 15));
      cnt_at[edge_cnt + 1] = int'(count);
      q.push_back(model(edge_cnt + 1));
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge; asserts reset mid-cycle
  task automatic do_reset();
    #3;
    rst = 1'b1;
    q.delete();
    #1;
    check("async_rst_an", {5'b0, an}, 7'h03);
    check("async_rst_seg", seg, 7'h7F);
    @(posedge clk);
    #1;
    check("held_rst_an", {5'b0, an}, 7'h03);
    check("held_rst_seg", seg, 7'h7F);
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    count = 4'd0;
    @(posedge clk);
    #1;
    check("init_rst_an", {5'b0, an}, 7'h03);
    check("init_rst_seg", seg, 7'h7F);
    rst = 1'b0;

    drive_cycles(12, 0, 0);          // first capture of 0
    do_reset();                      // mid-cycle async reset
    drive_cycles(16, 0, 7);
    drive_cycles(16, 0, 13);
    for (int v = 0; v < 16; v++) drive_cycles(8, 0, v);

    do_reset();
    drive_cycles(10, 0, 7);          // edge 10 lies inside the first DIG1 frame
    drive_cycles(8, 0, 12);          // ends inside the second DIG1 frame
    do_reset();                      // reset during DIG1
    drive_cycles(12, 0, 5);
    drive_cycles(12, 0, 15);

    for (int r = 0; r < 4; r++) begin
      drive_cycles(80 + 3 * r, 1, 0);
      do_reset();
    end
    drive_cycles(20, 1, 0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
